systolic_mm: RTL

Parametrised N×N output-stationary systolic matrix multiplier, next generation of the fixed 4×4 array. Computes C = A·B for an N×k by k×N operand pair streamed one k-step per beat. Internal input skew, a start/busy/done control FSM, valid/ready streaming on both sides, and row-serial result readout. Sits between the operand buffers and the result writeback path.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_pe.sv | 61 ++++++
 rtl/systolic_mm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic matrix multiplier.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package systolic_pkg;

  // Job control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  // Cycles of zero injection needed after the last beat lands in the input
  // register before the far corner PE has accumulated it.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Bits needed to hold values 0..maxval (at least one bit).
  function automatic int cnt_width(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: acc += a*b, a/b forwarded right/down.
// Latency: 1 cycle for a/b forwarding and for each accumulate.
// Backpressure: none, advances every cycle; clr zeroes all state.
// Build option: SYSTOLIC_ACC_SAT_EN selects an unsigned saturating accumulator.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod_full;
  logic [AW-1:0]   prod;
  logic [AW-1:0]   acc_nxt;

  assign prod_full = a_in * b_in;
  assign prod      = AW'(prod_full);

`ifdef SYSTOLIC_ACC_SAT_EN
  logic [AW:0] sum_ext;
  assign sum_ext = {1'b0, acc} + {1'b0, prod};

  // Clamp on carry-out; once at all-ones further adds keep it there.
  always_comb begin
    acc_nxt = sum_ext[AW-1:0];
    if (sum_ext[AW]) acc_nxt = '1;
  end
`else
  // Plain modulo-2^AW accumulation.
  always_comb begin
    acc_nxt = acc + prod;
  end
`endif

  // Pass registers and accumulator, cleared at job start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_mm.sv
// N x N output-stationary systolic multiplier C = A*B with skewed operand feed.
// Latency: last beat to first result row 2N cycles; one row per cycle after.
// Backpressure: in_ready only in STREAM; out_row held until out_ready.
// Build option: SYSTOLIC_ACC_SAT_EN makes every accumulator saturate.
module systolic_mm
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int AW   = 32,
  parameter int KMAX = 256,
  localparam int KW  = $clog2(KMAX + 1),
  localparam int IW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_row,
  output logic [IW-1:0]   out_idx,
  output logic            busy,
  output logic            done
);

  localparam int DRAIN_CYC = drain_cycles(N);
  localparam int DCW       = cnt_width(DRAIN_CYC);

  state_t         state;
  logic [KW-1:0]  k_len_q;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;

  logic job_start;
  logic fire;

  assign job_start = (state == ST_IDLE) && start;
  assign fire      = in_valid && in_ready;

  // Operand fabric: a flows east along rows, b flows south along columns.
  logic [DW-1:0]     a_bus   [N][N+1];
  logic [DW-1:0]     b_bus   [N+1][N];
  logic [AW-1:0]     acc_bus [N][N];
  logic [2*N*DW-1:0] edge_unused;

  // Job control: state, counters and all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_len_q  <= k_len;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (k_len != '0) begin
              state    <= ST_STREAM;
              in_ready <= 1'b1;
            end else begin
              // Empty inner dimension: cleared accumulators are the answer.
              state     <= ST_OUTPUT;
              out_valid <= 1'b1;
              out_idx   <= '0;
            end
          end
        end
        ST_STREAM: begin
          if (fire) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_len_q) begin
              state     <= ST_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // Last beat sits in the input register on entry; the far corner
          // PE consumes it DRAIN_CYC cycles later, results valid one after.
          if (drain_cnt == DCW'(DRAIN_CYC)) begin
            state     <= ST_OUTPUT;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (out_idx == IW'(N - 1)) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_idx   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Input register plus per-lane skew: lane i reaches the array edge i
  // cycles after lane 0, so A[i][k] and B[k][j] meet in PE(i,j).
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] sa [0:i];
    logic [DW-1:0] sb [0:i];

    // Shift chain; idle cycles push zeros so they add nothing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          sa[s] <= '0;
          sb[s] <= '0;
        end
      end else if (job_start) begin
        for (int s = 0; s <= i; s++) begin
          sa[s] <= '0;
          sb[s] <= '0;
        end
      end else begin
        sa[0] <= fire ? in_a[i*DW +: DW] : '0;
        sb[0] <= fire ? in_b[i*DW +: DW] : '0;
        for (int s = 1; s <= i; s++) begin
          sa[s] <= sa[s-1];
          sb[s] <= sb[s-1];
        end
      end
    end

    assign a_bus[i][0] = sa[i];
    assign b_bus[0][i] = sb[i];

    // Operands leaving the far edges are dropped.
    assign edge_unused[i*DW +: DW]     = a_bus[i][N];
    assign edge_unused[(N+i)*DW +: DW] = b_bus[N][i];
  end

  // N x N PE grid.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_start),
        .a_in  (a_bus[i][j]),
        .b_in  (b_bus[i][j]),
        .a_out (a_bus[i][j+1]),
        .b_out (b_bus[i+1][j]),
        .acc   (acc_bus[i][j])
      );
    end
  end

  // Row-serial readout straight from the accumulators, stable while held.
  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) begin
      out_row[j*AW +: AW] = acc_bus[out_idx][j];
    end
  end

endmodule
